// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and write-scheduler state encoding.
package fb_pkg;

  localparam int H_RES     = 320;
  localparam int V_RES     = 180;
  localparam int PIX_W     = 8;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int ADDR_W    = $clog2(FB_PIXELS);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves past whichever requester was granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic       ptr_r;
  logic [1:0] grant_s;

  // Grant the pointer's requester on contention, otherwise the lone valid one
  always_comb begin
    grant_s = 2'b00;
    if (!enable) begin
      grant_s = 2'b00;
    end else if (valid == 2'b11) begin
      grant_s = ptr_r ? 2'b10 : 2'b01;
    end else begin
      grant_s = valid;
    end
  end

  assign grant = grant_s;

  // Pointer update on every accepted grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (grant_s[0]) begin
      ptr_r <= 1'b1;
    end else if (grant_s[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port owner: arbitrates CPU/blitter writes, runs the clear
// engine and defers front/back swaps to vertical sync.
module fb_write_scheduler
  import fb_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            req_valid_in,
  output logic [1:0]            req_ready_out,
  input  logic [2*ADDR_W-1:0]   req_addr_in,
  input  logic [2*PIX_W-1:0]    req_data_in,
  input  logic                  clear_start_in,
  input  logic [PIX_W-1:0]      clear_color_in,
  output logic                  clear_busy_out,
  input  logic                  swap_req_in,
  input  logic                  vsync_in,
  output logic                  swap_pending_out,
  output logic                  front_sel_out,
  output logic                  fb_we_out,
  output logic [ADDR_W:0]       fb_addr_out,
  output logic [PIX_W-1:0]      fb_data_out
);

  fb_state_e         state_r;
  fb_state_e         next_state_s;
  logic [1:0]        grant_s;
  logic              arb_en_s;
  logic              clr_last_s;

  logic [ADDR_W-1:0] clr_cnt_r;
  logic [PIX_W-1:0]  clr_color_r;
  logic              pending_r;
  logic              front_r;
  logic              busy_r;
  logic              we_r;
  logic [ADDR_W:0]   addr_r;
  logic [PIX_W-1:0]  data_r;

  logic [ADDR_W-1:0] cnt_nxt_s;
  logic [PIX_W-1:0]  color_nxt_s;
  logic              pending_nxt_s;
  logic              front_nxt_s;
  logic              we_nxt_s;
  logic [ADDR_W:0]   addr_nxt_s;
  logic [PIX_W-1:0]  data_nxt_s;

  // A clear start steals the cycle, so nobody is granted alongside it
  assign arb_en_s   = (state_r == ARB) && !clear_start_in && !rst_in;
  assign clr_last_s = (clr_cnt_r == LAST_ADDR);

  rr_arbiter2 u_arb (
    .clk    (clk_in),
    .rst    (rst_in),
    .enable (arb_en_s),
    .valid  (req_valid_in),
    .grant  (grant_s)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ARB;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB: begin
        if (clear_start_in)   next_state_s = CLEAR;
        else if (swap_req_in) next_state_s = SWAP_WAIT;
        else                  next_state_s = ARB;
      end
      CLEAR: begin
        if (clr_last_s) next_state_s = (pending_r || swap_req_in) ? SWAP_WAIT : ARB;
        else            next_state_s = CLEAR;
      end
      SWAP_WAIT: begin
        if (vsync_in) next_state_s = ARB;
        else          next_state_s = SWAP_WAIT;
      end
      default: next_state_s = ARB;
    endcase
  end

  // Next values of the write port, clear counter and swap bookkeeping
  always_comb begin
    we_nxt_s      = 1'b0;
    addr_nxt_s    = addr_r;
    data_nxt_s    = data_r;
    cnt_nxt_s     = clr_cnt_r;
    color_nxt_s   = clr_color_r;
    pending_nxt_s = pending_r;
    front_nxt_s   = front_r;
    case (state_r)
      ARB: begin
        if (clear_start_in) begin
          // Beat 0 is issued straight from the start cycle
          we_nxt_s    = 1'b1;
          addr_nxt_s  = {~front_r, {ADDR_W{1'b0}}};
          data_nxt_s  = clear_color_in;
          cnt_nxt_s   = {ADDR_W{1'b0}};
          color_nxt_s = clear_color_in;
        end else if (grant_s[0]) begin
          we_nxt_s   = 1'b1;
          addr_nxt_s = {~front_r, req_addr_in[0 +: ADDR_W]};
          data_nxt_s = req_data_in[0 +: PIX_W];
        end else if (grant_s[1]) begin
          we_nxt_s   = 1'b1;
          addr_nxt_s = {~front_r, req_addr_in[ADDR_W +: ADDR_W]};
          data_nxt_s = req_data_in[PIX_W +: PIX_W];
        end else begin
          we_nxt_s = 1'b0;
        end
        if (swap_req_in) pending_nxt_s = 1'b1;
        else             pending_nxt_s = pending_r;
      end
      CLEAR: begin
        if (!clr_last_s) begin
          we_nxt_s   = 1'b1;
          cnt_nxt_s  = clr_cnt_r + ADDR_W'(1);
          addr_nxt_s = {~front_r, clr_cnt_r + ADDR_W'(1)};
          data_nxt_s = clr_color_r;
        end else begin
          we_nxt_s = 1'b0;
        end
        if (swap_req_in) pending_nxt_s = 1'b1;
        else             pending_nxt_s = pending_r;
      end
      SWAP_WAIT: begin
        if (vsync_in) begin
          pending_nxt_s = 1'b0;
          front_nxt_s   = ~front_r;
        end else begin
          pending_nxt_s = pending_r;
          front_nxt_s   = front_r;
        end
      end
      default: begin
        we_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered write port and status outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_r        <= 1'b0;
      addr_r      <= {(ADDR_W+1){1'b0}};
      data_r      <= {PIX_W{1'b0}};
      clr_cnt_r   <= {ADDR_W{1'b0}};
      clr_color_r <= {PIX_W{1'b0}};
      pending_r   <= 1'b0;
      front_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      we_r        <= we_nxt_s;
      addr_r      <= addr_nxt_s;
      data_r      <= data_nxt_s;
      clr_cnt_r   <= cnt_nxt_s;
      clr_color_r <= color_nxt_s;
      pending_r   <= pending_nxt_s;
      front_r     <= front_nxt_s;
      busy_r      <= (next_state_s == CLEAR);
    end
  end

  assign req_ready_out    = grant_s;
  assign clear_busy_out   = busy_r;
  assign swap_pending_out = pending_r;
  assign front_sel_out    = front_r;
  assign fb_we_out        = we_r;
  assign fb_addr_out      = addr_r;
  assign fb_data_out      = data_r;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler: directed stimulus pushes expected
// writes, a negedge monitor pops and compares every fb_we_out beat.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [1:0]          req_valid_in;
  logic [1:0]          req_ready_out;
  logic [2*ADDR_W-1:0] req_addr_in;
  logic [2*PIX_W-1:0]  req_data_in;
  logic                clear_start_in;
  logic [PIX_W-1:0]    clear_color_in;
  logic                clear_busy_out;
  logic                swap_req_in;
  logic                vsync_in;
  logic                swap_pending_out;
  logic                front_sel_out;
  logic                fb_we_out;
  logic [ADDR_W:0]     fb_addr_out;
  logic [PIX_W-1:0]    fb_data_out;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+PIX_W:0] sb[$];
  logic [ADDR_W+PIX_W:0] mon_exp;
  logic exp_front;
  int busy_cnt, ready_bad, front_bad, pend_cnt;
  bit done;

  fb_write_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .clear_start_in(clear_start_in), .clear_color_in(clear_color_in),
    .clear_busy_out(clear_busy_out), .swap_req_in(swap_req_in),
    .vsync_in(vsync_in), .swap_pending_out(swap_pending_out),
    .front_sel_out(front_sel_out), .fb_we_out(fb_we_out),
    .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic bsel, input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
    sb.push_back({bsel, a, d});
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard monitor: every write beat must match the oldest expectation
  always @(negedge clk_in) begin
    if (fb_we_out === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h with no write expected", fb_addr_out, fb_data_out);
      end else begin
        mon_exp = sb.pop_front();
        if ({fb_addr_out, fb_data_out} !== mon_exp) begin
          errors++;
          $display("FAIL fb_write: got addr=%h data=%h expected addr=%h data=%h",
                   fb_addr_out, fb_data_out, mon_exp[ADDR_W+PIX_W:PIX_W], mon_exp[PIX_W-1:0]);
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},      32'(fb_we_out), 32'd0);
    chk({tag, "_addr"},    32'(fb_addr_out), 32'd0);
    chk({tag, "_data"},    32'(fb_data_out), 32'd0);
    chk({tag, "_ready"},   32'(req_ready_out), 32'd0);
    chk({tag, "_busy"},    32'(clear_busy_out), 32'd0);
    chk({tag, "_pending"}, 32'(swap_pending_out), 32'd0);
    chk({tag, "_front"},   32'(front_sel_out), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; req_valid_in = 2'b00; clear_start_in = 1'b0; swap_req_in = 1'b0;
    vsync_in = 1'b0; clear_color_in = 8'h00;
    req_addr_in = {16'h0020, 16'h0010};
    req_data_in = {8'h22, 8'h11};
    exp_front = 1'b0;
    repeat (3) cyc();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_reset_state("reset");

    // Both requesters valid: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      cyc(); req_valid_in = 2'b11;
      @(negedge clk_in);
      chk("rr_alternate", 32'(req_ready_out), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 0) push_exp(~exp_front, 16'h0010, 8'h11);
      else            push_exp(~exp_front, 16'h0020, 8'h22);
    end
    // A lone grant to requester 0 still moves the pointer to requester 1
    cyc(); req_valid_in = 2'b01;
    @(negedge clk_in);
    chk("single_req0", 32'(req_ready_out), 32'd1);
    push_exp(~exp_front, 16'h0010, 8'h11);
    cyc(); req_valid_in = 2'b11;
    @(negedge clk_in);
    chk("ptr_after_single", 32'(req_ready_out), 32'd2);
    push_exp(~exp_front, 16'h0020, 8'h22);
    cyc(); req_valid_in = 2'b00;

    // Clear with a same-cycle swap request; vsyncs during the clear are ignored
    cyc(); clear_start_in = 1'b1; swap_req_in = 1'b1; clear_color_in = 8'h3C; req_valid_in = 2'b11;
    @(negedge clk_in);
    chk("clr_start_ready", 32'(req_ready_out), 32'd0);
    for (int k = 0; k < FB_PIXELS; k++) push_exp(~exp_front, ADDR_W'(k), 8'h3C);
    cyc(); clear_start_in = 1'b0; swap_req_in = 1'b0;
    busy_cnt = 0; ready_bad = 0; front_bad = 0; done = 1'b0;
    for (int c = 0; c < 60000 && !done; c++) begin
      @(negedge clk_in);
      if (clear_busy_out) begin
        busy_cnt++;
        if (req_ready_out != 2'b00) ready_bad++;
        if (front_sel_out != exp_front) front_bad++;
      end else begin
        done = 1'b1;
      end
      if (!done) begin
        cyc();
        vsync_in = (busy_cnt % 7000 == 0);
        clear_start_in = (busy_cnt == 100);
        clear_color_in = 8'h55;
      end
    end
    vsync_in = 1'b0; clear_start_in = 1'b0;
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd57600);
    chk("clr_ready_zero", 32'(ready_bad), 32'd0);
    chk("clr_front_stable", 32'(front_bad), 32'd0);
    chk("clr_swap_pending", 32'(swap_pending_out), 32'd1);
    chk("clr_after_ready", 32'(req_ready_out), 32'd0);
    req_valid_in = 2'b00;
    cyc(); vsync_in = 1'b1;
    @(negedge clk_in);
    chk("clr_front_pre_vsync", 32'(front_sel_out), 32'(exp_front));
    cyc(); vsync_in = 1'b0;
    exp_front = ~exp_front;
    @(negedge clk_in);
    chk("clr_front_swapped", 32'(front_sel_out), 32'(exp_front));
    chk("clr_pending_clear", 32'(swap_pending_out), 32'd0);

    // Swap request, vsync 100 cycles later; writes blocked meanwhile
    cyc(); swap_req_in = 1'b1;
    @(negedge clk_in);
    chk("swap_pending_before", 32'(swap_pending_out), 32'd0);
    pend_cnt = 0; ready_bad = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(); swap_req_in = 1'b0; req_valid_in = 2'b11; vsync_in = (i == 100);
      @(negedge clk_in);
      if (swap_pending_out) pend_cnt++;
      if (req_ready_out != 2'b00) ready_bad++;
    end
    cyc(); vsync_in = 1'b0;
    exp_front = ~exp_front;
    @(negedge clk_in);
    chk("swap_pending_cycles", 32'(pend_cnt), 32'd100);
    chk("swap_ready_blocked", 32'(ready_bad), 32'd0);
    chk("swap_front", 32'(front_sel_out), 32'(exp_front));
    chk("swap_pending_done", 32'(swap_pending_out), 32'd0);
    chk("swap_next_grant", 32'(req_ready_out), 32'd1);
    push_exp(~exp_front, 16'h0010, 8'h11);
    cyc(); req_valid_in = 2'b00;

    // Second swap request while pending, then two vsyncs: one toggle only
    cyc(); swap_req_in = 1'b1;
    cyc(); swap_req_in = 1'b0;
    cyc(); swap_req_in = 1'b1;
    cyc(); swap_req_in = 1'b0;
    @(negedge clk_in);
    chk("dbl_pending", 32'(swap_pending_out), 32'd1);
    cyc(); vsync_in = 1'b1;
    cyc(); vsync_in = 1'b0;
    exp_front = ~exp_front;
    @(negedge clk_in);
    chk("dbl_first_vsync", 32'(front_sel_out), 32'(exp_front));
    cyc(); cyc(); vsync_in = 1'b1;
    cyc(); vsync_in = 1'b0;
    @(negedge clk_in);
    chk("dbl_second_vsync", 32'(front_sel_out), 32'(exp_front));
    chk("dbl_pending_done", 32'(swap_pending_out), 32'd0);

    // Swap request and vsync in the same cycle: swap waits for the next vsync
    cyc(); swap_req_in = 1'b1; vsync_in = 1'b1;
    cyc(); swap_req_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk_in);
    chk("same_cyc_pending", 32'(swap_pending_out), 32'd1);
    chk("same_cyc_front", 32'(front_sel_out), 32'(exp_front));
    cyc(); vsync_in = 1'b1;
    cyc(); vsync_in = 1'b0;
    exp_front = ~exp_front;
    @(negedge clk_in);
    chk("same_cyc_swapped", 32'(front_sel_out), 32'(exp_front));

    // Reset at clear beat 1000 with a swap pending
    cyc(); clear_start_in = 1'b1; swap_req_in = 1'b1; clear_color_in = 8'hA5;
    @(negedge clk_in);
    for (int k = 0; k < 1000; k++) push_exp(~exp_front, ADDR_W'(k), 8'hA5);
    cyc(); clear_start_in = 1'b0; swap_req_in = 1'b0;
    repeat (999) cyc();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("pre_rst_busy", 32'(clear_busy_out), 32'd1);
    chk("pre_rst_pending", 32'(swap_pending_out), 32'd1);
    cyc(); rst_in = 1'b0;
    exp_front = 1'b0;
    @(negedge clk_in);
    chk_reset_state("mid_rst");
    cyc(); req_valid_in = 2'b11;
    @(negedge clk_in);
    chk("post_rst_grant", 32'(req_ready_out), 32'd1);
    push_exp(~exp_front, 16'h0010, 8'h11);
    cyc(); req_valid_in = 2'b00;
    repeat (3) cyc();
    @(negedge clk_in);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sole write-side controller for the double-buffered frame buffer.
- Shares the single frame-buffer write port among two pixel-write requesters (0 = CPU, 1 = blitter) and an internal clear-screen engine.
- Schedules front/back buffer swaps so they happen only at vertical sync, avoiding tearing.
- Runs in the system clock domain. vsync_in arrives already synchronized into this domain as a one-cycle pulse.

Parameters:
- H_RES, 320, frame-buffer width in pixels.
- V_RES, 180, frame-buffer height in pixels.
- PIX_W, 8, bits per pixel word.
- ADDR_W, $clog2(H_RES*V_RES) (16), pixel address width within one buffer.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- req_valid_in  input  2  per-requester write valid.
- req_ready_out  output  2  per-requester grant/accept; a write transfers when valid & ready.
- req_addr_in  input  2*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_data_in  input  2*PIX_W  packed pixel data, same packing.
- clear_start_in  input  1  one-cycle pulse: fill the back buffer with clear_color_in.
- clear_color_in  input  PIX_W  fill value, sampled on the accepted clear_start_in.
- clear_busy_out  output  1  high while clearing.
- swap_req_in  input  1  one-cycle pulse: request a buffer swap at the next vsync.
- vsync_in  input  1  one-cycle pulse at the start of vertical blanking.
- swap_pending_out  output  1  swap requested but not yet performed.
- front_sel_out  output  1  buffer currently displayed; writes target ~front_sel_out.
- fb_we_out  output  1  frame-buffer write enable.
- fb_addr_out  output  ADDR_W+1  {buffer select, pixel address}.
- fb_data_out  output  PIX_W  write data.

Behaviour:
- Reset values: fb_we_out=0, fb_addr_out=0, fb_data_out=0, req_ready_out=0, clear_busy_out=0, swap_pending_out=0, front_sel_out=0. State=ARB. Round-robin pointer=0 (requester 0 favoured first).
- Reset mid-clear or mid-pending: the operation is abandoned; no write is issued on the reset cycle.
- FSM states:
  - ARB: normal arbitration.
  - CLEAR: sequential fill.
  - SWAP_WAIT: writes blocked until vsync.
- ARB arbitration:
  - req_ready_out is combinational from valid, the RR pointer and the state.
  - At most one bit is high, and only in ARB.
  - If both requesters are valid, grant goes to the pointer's requester, then the pointer moves to the other one.
  - If only one is valid, it is granted and the pointer moves to the other one.
- Write latency: one cycle. The accepted write appears on the registered fb_* outputs on the next cycle, with fb_addr_out = {~front_sel_out, addr}.
- ARB -> CLEAR on clear_start_in:
  - Takes precedence over the same-cycle swap_req_in, which is still latched as pending. The resulting swap is deferred until the clear completes.
  - No requester is granted in that cycle.
- CLEAR sequencing:
  - Writes addresses 0 .. H_RES*V_RES-1, one per cycle, to the back buffer. First write lands one cycle after the accepted start; total 57600 writes.
  - clear_busy_out rises the cycle after the start and falls in the cycle after the last write is issued.
  - All ready bits are 0 throughout.
  - clear_start_in during CLEAR is ignored.
  - On completion: go to SWAP_WAIT if a swap is pending, else ARB.
- ARB -> SWAP_WAIT on swap_req_in:
  - swap_pending_out=1 from the next cycle.
  - Ready bits are 0 in SWAP_WAIT, so no back-buffer writes happen after the swap request.
- SWAP_WAIT exit on vsync_in:
  - front_sel_out toggles; swap_pending_out clears; next state ARB. Takes effect the cycle after vsync_in.
  - Pending takes effect only while in SWAP_WAIT. A vsync during CLEAR, or with no swap pending, does nothing.
- Ignored or merged events:
  - swap_req_in while already pending is ignored (no double toggle).
  - swap_req_in and vsync_in in the same ARB cycle: the swap waits for the next vsync.
  - clear_start_in in SWAP_WAIT is ignored.
- fb_we_out is deasserted in any cycle with no accepted write or clear beat.
- Address arithmetic: the clear counter is ADDR_W bits and terminates at H_RES*V_RES-1. There is no wrap.

Decomposition:
- Package fb_pkg holds:
  - H_RES, V_RES, PIX_W, ADDR_W, FB_PIXELS.
  - An enum for the FSM state (ARB, CLEAR, SWAP_WAIT).
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with pointer update on accept).

Test Plan:
- Both requesters are held valid with addrs 0x0010/0x0020 after reset -> grants alternate 0,1,0,1. fb_addr_out = {1, 0x0010}, then {1, 0x0020}, each one cycle after acceptance.
- clear_start_in with color 0x3C -> clear_busy_out high for exactly 57600 cycles. fb_we_out writes 0x3C to {1, 0x0000} .. {1, 0xE0FF} consecutively. Ready stays 0 throughout.
- swap_req_in, then vsync_in 100 cycles later -> swap_pending_out high for 100 cycles, ready 0 throughout, then front_sel_out=1. The next write goes to {0, addr}.
- clear_start_in and swap_req_in in the same cycle, with vsync pulses during the clear -> front_sel_out does not change until the first vsync after clear_busy_out falls.
- A second swap_req_in while pending, followed by two vsyncs -> front_sel_out toggles exactly once.
- rst_in asserted at clear beat 1000 -> the next cycle has all outputs at reset values. A following request is granted to requester 0.
